sdram_responder: RTL
====================

SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter ROW_BITS, default 4, meaning number of row-address bits stored per bank (taken from a[ROW_BITS-1:0]).
REQ-002 SHALL have parameter COL_BITS, default 8, meaning column bits taken from a[COL_BITS-1:0]; memory depth is 4*2^ROW_BITS*2^COL_BITS 16-bit words.
REQ-003 SHALL have parameter TRCD, default 2, meaning the minimum number of cycles from ACTIVE to READ/WRITE on the same bank.
REQ-004 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock; one clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sdram_cke  in  1  clock enable; when low, commands are ignored.
- sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe  in  1 each  command bits, encoded as {nCS,nRAS,nCAS,nWE}.
- sdram_ba  in  2  bank.
- sdram_a  in  12  multiplexed address; a[10] is all-banks/auto-precharge.
- sdram_dqml, sdram_dqmh  in  1 each  byte masks.
- dq_in  in  16  write data from the initiator.
- dq_out  out  16  read data.
- dq_oe  out  1  read-data drive enable.
- mode_reg  out  12  last loaded mode word.
- refresh_cnt  out  16  count of AUTO_REFRESH commands, saturating.
- err_proto  out  1  sticky protocol-error flag.

Function
REQ-005 SHALL decode a command only on edges where sdram_cke=1; nCS=1 (INHIBIT) and 0111 (NOP) SHALL have no effect.
REQ-006 On LOAD_MODE (0000), mode_reg SHALL take a; the CAS latency SHALL become a[6:4], and a value other than 2 or 3 SHALL set err_proto and keep CL unchanged.
REQ-007 On ACTIVE (0011), the bank ba SHALL open with row a[ROW_BITS-1:0] and its TRCD counter SHALL load; ACTIVE to an already-open bank SHALL set err_proto and reload the row.
REQ-008 On READ (0101) sampled at edge N to an open bank, word {ba,row,col} SHALL drive dq_out with dq_oe=1 for exactly the one cycle following edge N+CL-1, so the initiator samples it at edge N+CL.
- A byte whose DQM was high at edge N SHALL read as 8'h00.
REQ-009 Reads SHALL be pipelined: back-to-back READs on consecutive cycles SHALL each produce one data cycle at its own latency.
REQ-010 On WRITE (0100) to an open bank, dq_in SHALL be written at edge N with per-byte enable ~dqmh/~dqml; both masks high SHALL write nothing.
REQ-011 On READ or WRITE with a[10]=1, the bank SHALL close after the access is issued (auto-precharge).
REQ-012 On READ or WRITE to a closed bank, err_proto SHALL be set, no memory write SHALL occur, and no data cycle SHALL be produced.
REQ-013 On PRECHARGE (0010), a[10]=1 SHALL close all banks; otherwise only bank ba SHALL close. Precharge of a closed bank is legal.
REQ-014 On AUTO_REFRESH (0001), refresh_cnt SHALL increment, saturating at 16'hFFFF; if any bank is open, err_proto SHALL be set.
REQ-015 Mode burst length a[2:0] other than 000 SHALL set err_proto at LOAD_MODE; the block SHALL always behave as burst length 1.
REQ-016 A WRITE sampled in the same cycle that dq_oe=1 SHALL set err_proto (bus contention); the write SHALL still occur.
REQ-017 err_proto SHALL remain set until reset.

Reset
REQ-018 Reset SHALL close all banks, clear the TRCD counters, set mode_reg=0 and CL=2, flush the read pipeline, and set dq_oe=0, dq_out=0, refresh_cnt=0 and err_proto=0, all on the next edge.
REQ-019 Reset asserted mid-read SHALL discard the pending data, with no data cycle afterwards.
REQ-020 Memory contents SHALL NOT be reset.

Configuration
REQ-021 With SDRAM_RESPONDER_CHECK_EN defined, a READ or WRITE issued fewer than TRCD cycles after ACTIVE on the same bank SHALL set err_proto, and the access SHALL still execute.
REQ-022 Without SDRAM_RESPONDER_CHECK_EN, the TRCD counters SHALL be absent and REQ-016/REQ-021 SHALL not flag; all other error sources SHALL remain.

Structure
REQ-023 Package sdram_pkg SHALL hold the 4-bit CMD_* encodings (INHIBIT, NOP, ACTIVE, READ, WRITE, BURST_TERMINATE, PRECHARGE, AUTO_REFRESH, LOAD_MODE) and the mode-field positions (CL, BL, write-burst bit).
REQ-024 Sub-module sdram_resp_mem SHALL provide a single-port, byte-enabled, 16-bit synchronous RAM with a one-cycle read.

Verification
REQ-025 Reset, then LOAD_MODE a=12'h220; ACTIVE ba=1 a=3; WRITE ba=1 a=12'h005 dq_in=16'hBEEF; READ ba=1 a=12'h005 at edge N -> dq_out=16'hBEEF with dq_oe=1, sampleable at edge N+2, and err_proto=0.
REQ-026 LOAD_MODE a=12'h230 (CL=3), then a READ -> data sampleable at N+3; reads on three consecutive cycles -> three consecutive dq_oe cycles.
REQ-027 WRITE 16'h1234 with dqmh=1 over a word holding 16'hBEEF -> a READ returns 16'hBE34.
REQ-028 READ to a closed bank 2 -> err_proto=1 and no dq_oe; AUTO_REFRESH with bank 0 open -> err_proto=1 and refresh_cnt=1.
REQ-029 PRECHARGE a[10]=1 then AUTO_REFRESH x3 -> refresh_cnt=3 and err_proto=0; READ with a[10]=1 then READ on the same bank -> err_proto=1.
REQ-030 With the macro defined, ACTIVE then READ on the next cycle (TRCD=2) -> err_proto=1; reset asserted one cycle after a READ -> dq_oe stays 0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, mode-word field positions and byte-mask helpers
// for the sdram_responder target model.
package sdram_pkg;

  // Command word is {nCS, nRAS, nCAS, nWE}; any code with nCS=1 is INHIBIT.
  localparam logic [3:0] CMD_INHIBIT         = 4'b1111;
  localparam logic [3:0] CMD_NOP             = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE          = 4'b0011;
  localparam logic [3:0] CMD_READ            = 4'b0101;
  localparam logic [3:0] CMD_WRITE           = 4'b0100;
  localparam logic [3:0] CMD_BURST_TERMINATE = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE       = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH    = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE       = 4'b0000;

  localparam int MODE_CL_LSB = 4;
  localparam int MODE_CL_MSB = 6;
  localparam int MODE_BL_LSB = 0;
  localparam int MODE_BL_MSB = 2;
  localparam int MODE_WB_BIT = 9;
  localparam int A_AP_BIT    = 10;

  function automatic logic cl_supported(input logic [2:0] cl);
    return (cl == 3'd2) || (cl == 3'd3);
  endfunction

  function automatic logic [15:0] mask_bytes(input logic [15:0] data, input logic [1:0] dqm);
    return {dqm[1] ? 8'h00 : data[15:8], dqm[0] ? 8'h00 : data[7:0]};
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Single-port 16-bit synchronous RAM with per-byte write enables and a
// registered (one-cycle) read; contents are never reset.
module sdram_resp_mem #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [1:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_wdata,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [0:(1<<AW)-1];
  logic [15:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 2; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sdram_responder.sv
// SDRAM target model: 4 banks, CL2/CL3 pipelined single-beat reads, sticky protocol checks.
// Define SDRAM_RESPONDER_CHECK_EN to add tRCD and read/write bus-contention checks.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 8,
  parameter int TRCD     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sdram_cke,
  input  logic        sdram_ncs,
  input  logic        sdram_nras,
  input  logic        sdram_ncas,
  input  logic        sdram_nwe,
  input  logic [1:0]  sdram_ba,
  input  logic [11:0] sdram_a,
  input  logic        sdram_dqml,
  input  logic        sdram_dqmh,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic [11:0] mode_reg,
  output logic [15:0] refresh_cnt,
  output logic        err_proto
);

  localparam int AW = 2 + ROW_BITS + COL_BITS;

  logic [3:0]          w_cmd;
  logic                w_live;
  logic                w_cmd_act, w_cmd_rd, w_cmd_wr, w_cmd_pre, w_cmd_ref, w_cmd_lmr;
  logic [3:0]          w_open;
  logic [ROW_BITS-1:0] w_row [4];
  logic                w_bank_open;
  logic [ROW_BITS-1:0] w_sel_row;
  logic                w_access;
  logic                w_err_now;
  logic [15:0]         w_mem_rdata;
  logic [15:0]         w_p1_data;

  logic                r_p1_valid;
  logic [1:0]          r_p1_dqm;
  logic                r_p2_valid;
  logic [15:0]         r_p2_data;
  logic                r_dq_oe;
  logic [15:0]         r_dq_out;
  logic [11:0]         r_mode;
  logic [2:0]          r_cl;
  logic [15:0]         r_ref;
  logic                r_err;

  assign w_cmd     = {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe};
  assign w_live    = sdram_cke & ~reset;
  assign w_cmd_act = w_live && (w_cmd == CMD_ACTIVE);
  assign w_cmd_rd  = w_live && (w_cmd == CMD_READ);
  assign w_cmd_wr  = w_live && (w_cmd == CMD_WRITE);
  assign w_cmd_pre = w_live && (w_cmd == CMD_PRECHARGE);
  assign w_cmd_ref = w_live && (w_cmd == CMD_AUTO_REFRESH);
  assign w_cmd_lmr = w_live && (w_cmd == CMD_LOAD_MODE);

  assign w_bank_open = w_open[sdram_ba];
  assign w_sel_row   = w_row[sdram_ba];
  assign w_access    = (w_cmd_rd || w_cmd_wr) && w_bank_open;

`ifdef SDRAM_RESPONDER_CHECK_EN
  localparam int TW = (TRCD < 2) ? 1 : $clog2(TRCD);
  logic [3:0] w_trcd_busy;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic                r_open;
      logic [ROW_BITS-1:0] r_row;
      logic                w_hit;

      assign w_hit = (sdram_ba == 2'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          r_open <= 1'b0;
          r_row  <= '0;
        end else if (w_cmd_act && w_hit) begin
          r_open <= 1'b1;
          r_row  <= sdram_a[ROW_BITS-1:0];
        end else if ((w_cmd_pre && (sdram_a[A_AP_BIT] || w_hit)) ||
                     ((w_cmd_rd || w_cmd_wr) && sdram_a[A_AP_BIT] && w_hit)) begin
          r_open <= 1'b0;
        end
      end

      assign w_open[gi] = r_open;
      assign w_row[gi]  = r_row;

`ifdef SDRAM_RESPONDER_CHECK_EN
      // Counts down the cycles still forbidden for READ/WRITE after ACTIVE.
      logic [TW-1:0] r_trcd;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_trcd <= '0;
        end else if (w_cmd_act && w_hit) begin
          r_trcd <= TW'((TRCD > 0) ? TRCD - 1 : 0);
        end else if (r_trcd != '0) begin
          r_trcd <= r_trcd - 1'b1;
        end
      end
      assign w_trcd_busy[gi] = (r_trcd != '0);
`endif
    end
  endgenerate

  always_comb begin
    w_err_now = 1'b0;
    if (w_cmd_lmr && (!cl_supported(sdram_a[MODE_CL_MSB:MODE_CL_LSB]) ||
                      (sdram_a[MODE_BL_MSB:MODE_BL_LSB] != 3'd0)))
      w_err_now = 1'b1;
    if (w_cmd_act && w_bank_open) w_err_now = 1'b1;
    if ((w_cmd_rd || w_cmd_wr) && !w_bank_open) w_err_now = 1'b1;
    if (w_cmd_ref && (|w_open)) w_err_now = 1'b1;
`ifdef SDRAM_RESPONDER_CHECK_EN
    if ((w_cmd_rd || w_cmd_wr) && w_trcd_busy[sdram_ba]) w_err_now = 1'b1;
    if (w_cmd_wr && r_dq_oe) w_err_now = 1'b1;
`endif
  end

  sdram_resp_mem #(.AW(AW)) u_mem (
    .clk     (clk),
    .i_en    (w_access),
    .i_we    (w_cmd_wr),
    .i_be    (~{sdram_dqmh, sdram_dqml}),
    .i_addr  ({sdram_ba, w_sel_row, sdram_a[COL_BITS-1:0]}),
    .i_wdata (dq_in),
    .o_rdata (w_mem_rdata)
  );

  assign w_p1_data = mask_bytes(w_mem_rdata, r_p1_dqm);

  // RAM output lands one edge after READ; CL3 adds one more register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1_valid <= 1'b0;
      r_p1_dqm   <= 2'b00;
      r_p2_valid <= 1'b0;
      r_p2_data  <= '0;
      r_dq_oe    <= 1'b0;
      r_dq_out   <= '0;
    end else begin
      r_p1_valid <= w_cmd_rd && w_bank_open;
      r_p1_dqm   <= {sdram_dqmh, sdram_dqml};
      r_p2_valid <= r_p1_valid;
      r_p2_data  <= w_p1_data;
      if (r_cl == 3'd3) begin
        r_dq_oe  <= r_p2_valid;
        r_dq_out <= r_p2_valid ? r_p2_data : 16'h0000;
      end else begin
        r_dq_oe  <= r_p1_valid;
        r_dq_out <= r_p1_valid ? w_p1_data : 16'h0000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= '0;
      r_cl   <= 3'd2;
      r_ref  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_cmd_lmr) begin
        r_mode <= sdram_a;
        if (cl_supported(sdram_a[MODE_CL_MSB:MODE_CL_LSB]))
          r_cl <= sdram_a[MODE_CL_MSB:MODE_CL_LSB];
      end
      if (w_cmd_ref && (r_ref != 16'hFFFF)) r_ref <= r_ref + 16'd1;
      if (w_err_now) r_err <= 1'b1;
    end
  end

  assign dq_out      = r_dq_out;
  assign dq_oe       = r_dq_oe;
  assign mode_reg    = r_mode;
  assign refresh_cnt = r_ref;
  assign err_proto   = r_err;

endmodule
